// File: rtl/klein_keyschedule_stream.sv
// KLEIN-64/80/96 key schedule: streams round keys 0..NROUNDS over valid/ready,
// or runs one round per cycle to the final key state used by decryption.

module klein_sbox (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    always_comb begin
        dout = 4'h0;
        case (din)
            4'h0: dout = 4'h7;
            4'h1: dout = 4'h4;
            4'h2: dout = 4'hA;
            4'h3: dout = 4'h9;
            4'h4: dout = 4'h1;
            4'h5: dout = 4'hF;
            4'h6: dout = 4'hB;
            4'h7: dout = 4'h0;
            4'h8: dout = 4'hC;
            4'h9: dout = 4'h3;
            4'hA: dout = 4'h2;
            4'hB: dout = 4'h6;
            4'hC: dout = 4'h8;
            4'hD: dout = 4'hE;
            4'hE: dout = 4'hD;
            4'hF: dout = 4'h5;
        endcase
    end
endmodule

module klein_keyschedule_stream #(
    parameter int KEY_WIDTH = 64,
    parameter int NROUNDS   = 12
) (
    input  logic                 iclk,
    input  logic                 ireset,
    input  logic                 istart,
    input  logic                 imode,
    input  logic [KEY_WIDTH-1:0] ikey,
    output logic [63:0]          okey,
    output logic [4:0]           oidx,
    output logic                 ovalid,
    input  logic                 iready,
    output logic [KEY_WIDTH-1:0] ofinal,
    output logic                 odone,
    output logic                 obusy
);
    localparam int         H  = KEY_WIDTH / 2;
    localparam logic [4:0] NR = 5'(NROUNDS);

    typedef enum logic [1:0] {IDLE, STREAM, RUN} state_t;

    state_t               state;
    logic [KEY_WIDTH-1:0] s;
    logic [KEY_WIDTH-1:0] nxt;
    logic [4:0]           cnt;
    logic [4:0]           rc;
    logic [H-1:0]         a, b, ra, rb, mix, na, nb;
    logic [15:0]          sb;

    // Key state is MSB-first: spec bit i lives at s[KEY_WIDTH-1-i].
    assign a   = s[KEY_WIDTH-1 -: H];
    assign b   = s[H-1:0];
    assign ra  = {a[H-9:0], a[H-1 -: 8]};
    assign rb  = {b[H-9:0], b[H-1 -: 8]};
    assign mix = ra ^ rb;
    assign rc  = cnt + 5'd1;

    for (genvar j = 0; j < 4; j++) begin : g_sbox
        klein_sbox u_sbox (
            .din  (mix[H-9-4*j -: 4]),
            .dout (sb[15-4*j -: 4])
        );
    end

    always_comb begin
        na              = rb;
        na[H-17 -: 8]   = rb[H-17 -: 8] ^ {3'b000, rc};
        nb              = mix;
        nb[H-9 -: 16]   = sb;
    end

    assign nxt  = {na, nb};
    assign okey = s[KEY_WIDTH-1 -: 64];
    assign oidx = cnt;

    always_ff @(posedge iclk) begin
        if (ireset) begin
            state  <= IDLE;
            s      <= '0;
            cnt    <= '0;
            ovalid <= 1'b0;
            ofinal <= '0;
            odone  <= 1'b0;
            obusy  <= 1'b0;
        end else begin
            odone <= 1'b0;
            case (state)
                IDLE: begin
                    if (istart) begin
                        s     <= ikey;
                        cnt   <= '0;
                        obusy <= 1'b1;
                        if (imode) begin
                            state <= RUN;
                        end else begin
                            state  <= STREAM;
                            ovalid <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    // ovalid is constantly high here, so iready alone completes the handshake.
                    if (iready) begin
                        if (cnt == NR) begin
                            ofinal <= s;
                            odone  <= 1'b1;
                            ovalid <= 1'b0;
                            obusy  <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            s   <= nxt;
                            cnt <= rc;
                        end
                    end
                end
                RUN: begin
                    s   <= nxt;
                    cnt <= rc;
                    if (rc == NR) begin
                        ofinal <= nxt;
                        odone  <= 1'b1;
                        obusy  <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_klein_keyschedule_stream.sv
// Directed bench for klein_keyschedule_stream at 64/12, 80/16 and 96/20 with a
// bit-level reference model and a round-key scoreboard.

module tb_klein_keyschedule_stream;
    logic        iclk = 1'b0;
    always #5 iclk = ~iclk;

    logic        ireset, istart, imode, iready;
    logic [95:0] ikey;
    int          sel;
    logic        st64, st80, st96;

    logic [63:0] okey64, okey80, okey96;
    logic [4:0]  oidx64, oidx80, oidx96;
    logic        ovalid64, ovalid80, ovalid96;
    logic        odone64, odone80, odone96;
    logic        obusy64, obusy80, obusy96;
    logic [63:0] ofinal64;
    logic [79:0] ofinal80;
    logic [95:0] ofinal96;

    logic [63:0] okey_m;
    logic [4:0]  oidx_m;
    logic        ovalid_m, odone_m, obusy_m;
    logic [95:0] ofinal_m;

    int          nvec = 0;
    int          nerr = 0;
    logic [68:0] sbq[$];
    logic [63:0] seen[0:31];

    assign st64 = istart && (sel == 0);
    assign st80 = istart && (sel == 1);
    assign st96 = istart && (sel == 2);

    klein_keyschedule_stream #(.KEY_WIDTH(64), .NROUNDS(12)) u64 (
        .iclk(iclk), .ireset(ireset), .istart(st64), .imode(imode), .ikey(ikey[63:0]),
        .okey(okey64), .oidx(oidx64), .ovalid(ovalid64), .iready(iready),
        .ofinal(ofinal64), .odone(odone64), .obusy(obusy64));
    klein_keyschedule_stream #(.KEY_WIDTH(80), .NROUNDS(16)) u80 (
        .iclk(iclk), .ireset(ireset), .istart(st80), .imode(imode), .ikey(ikey[79:0]),
        .okey(okey80), .oidx(oidx80), .ovalid(ovalid80), .iready(iready),
        .ofinal(ofinal80), .odone(odone80), .obusy(obusy80));
    klein_keyschedule_stream #(.KEY_WIDTH(96), .NROUNDS(20)) u96 (
        .iclk(iclk), .ireset(ireset), .istart(st96), .imode(imode), .ikey(ikey),
        .okey(okey96), .oidx(oidx96), .ovalid(ovalid96), .iready(iready),
        .ofinal(ofinal96), .odone(odone96), .obusy(obusy96));

    always_comb begin
        okey_m = okey64; oidx_m = oidx64; ovalid_m = ovalid64;
        odone_m = odone64; obusy_m = obusy64; ofinal_m = {32'b0, ofinal64};
        if (sel == 1) begin
            okey_m = okey80; oidx_m = oidx80; ovalid_m = ovalid80;
            odone_m = odone80; obusy_m = obusy80; ofinal_m = {16'b0, ofinal80};
        end else if (sel == 2) begin
            okey_m = okey96; oidx_m = oidx96; ovalid_m = ovalid96;
            odone_m = odone96; obusy_m = obusy96; ofinal_m = ofinal96;
        end
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference round, written bit-by-bit in MSB-first numbering; key right-aligned in 96 bits.
    function automatic logic [95:0] mround(input logic [95:0] s, input int kw, input logic [4:0] c);
        logic [0:47] a, b, ra, rb, na, nb;
        logic [63:0] tbl;
        logic [7:0]  cb;
        logic [3:0]  nib, sub;
        logic [95:0] r;
        int          h;
        h = kw / 2;
        tbl = 64'h74A91FB0C3268ED5;
        cb = {3'b000, c};
        a = '0; b = '0; ra = '0; rb = '0; na = '0; nb = '0; r = '0;
        for (int i = 0; i < h; i++) begin
            a[i] = s[kw-1-i];
            b[i] = s[kw-1-h-i];
        end
        for (int i = 0; i < h; i++) begin
            ra[i] = a[(i+8) % h];
            rb[i] = b[(i+8) % h];
        end
        for (int i = 0; i < h; i++) begin
            na[i] = rb[i];
            nb[i] = ra[i] ^ rb[i];
        end
        for (int i = 0; i < 8; i++) na[16+i] = na[16+i] ^ cb[7-i];
        for (int n = 0; n < 4; n++) begin
            nib = {nb[8+4*n], nb[9+4*n], nb[10+4*n], nb[11+4*n]};
            sub = tbl[63-4*int'(nib) -: 4];
            nb[8+4*n] = sub[3]; nb[9+4*n] = sub[2]; nb[10+4*n] = sub[1]; nb[11+4*n] = sub[0];
        end
        for (int i = 0; i < h; i++) begin
            r[kw-1-i]   = na[i];
            r[kw-1-h-i] = nb[i];
        end
        return r;
    endfunction

    task automatic run_stream(input logic [95:0] key, input int kw, input int nr, input int lowpct,
                              input bit poke, input string tag, output logic [95:0] fin);
        logic [95:0] s;
        logic [68:0] e;
        logic [63:0] hk;
        logic [4:0]  hi;
        int          cyc, hs;
        bit          stall, rdy, done;
        fin = '0; s = key; hk = '0; hi = '0; e = '0;
        sbq.delete();
        sbq.push_back({5'd0, s[kw-1 -: 64]});
        for (int r = 1; r <= nr; r++) begin
            s = mround(s, kw, 5'(r));
            sbq.push_back({5'(r), s[kw-1 -: 64]});
        end
        istart = 1'b1; imode = 1'b0; ikey = key;
        iready = ($urandom_range(99) >= 32'(lowpct));
        @(negedge iclk);
        istart = 1'b0; cyc = 1; hs = 0; stall = 0; done = 0;
        chk({tag, "_busy1"}, 96'(obusy_m), 96'(1));
        while (!done && cyc < 600) begin
            if (odone_m) begin
                done = 1;
                chk({tag, "_done_vs_valid"}, 96'(ovalid_m), 96'(0));
                chk({tag, "_handshakes"}, 96'(hs), 96'(nr + 1));
                if (lowpct == 0) chk({tag, "_done_cycle"}, 96'(cyc), 96'(nr + 2));
                chk({tag, "_busy_at_done"}, 96'(obusy_m), 96'(0));
                chk({tag, "_ofinal"}, ofinal_m, s);
                chk({tag, "_queue_empty"}, 96'(sbq.size()), 96'(0));
                fin = ofinal_m;
            end else begin
                chk({tag, "_valid"}, 96'(ovalid_m), 96'(1));
                if (stall) begin
                    chk({tag, "_hold_key"}, 96'(okey_m), 96'(hk));
                    chk({tag, "_hold_idx"}, 96'(oidx_m), 96'(hi));
                end
                rdy = ($urandom_range(99) >= 32'(lowpct));
                if (poke && cyc == 3) begin
                    istart = 1'b1; imode = 1'b1; ikey = ~key;
                end else begin
                    istart = 1'b0;
                end
                if (ovalid_m && rdy) begin
                    if (sbq.size() == 0) begin
                        chk({tag, "_extra_handshake"}, 96'(oidx_m), 96'(31));
                    end else begin
                        e = sbq.pop_front();
                        chk({tag, "_idx"}, 96'(oidx_m), 96'(e[68:64]));
                        chk({tag, "_key"}, 96'(okey_m), 96'(e[63:0]));
                        seen[e[68:64]] = okey_m;
                    end
                    hs++;
                    stall = 0;
                end else begin
                    stall = 1; hk = okey_m; hi = oidx_m;
                end
                iready = rdy;
                @(negedge iclk);
                cyc++;
            end
        end
        if (!done) chk({tag, "_timeout"}, 96'(0), 96'(1));
        istart = 1'b0;
    endtask

    task automatic run_final(input logic [95:0] key, input int kw, input int nr, input bit poke,
                             input string tag, output logic [95:0] fin);
        logic [95:0] s;
        int          cyc;
        bit          done;
        fin = '0; s = key;
        for (int r = 1; r <= nr; r++) s = mround(s, kw, 5'(r));
        istart = 1'b1; imode = 1'b1; ikey = key;
        @(negedge iclk);
        istart = 1'b0; cyc = 1; done = 0;
        chk({tag, "_busy1"}, 96'(obusy_m), 96'(1));
        chk({tag, "_done_pulse"}, 96'(odone_m), 96'(0));
        while (!done && cyc < 600) begin
            if (odone_m) begin
                done = 1;
                chk({tag, "_done_cycle"}, 96'(cyc), 96'(nr + 1));
                chk({tag, "_ofinal"}, ofinal_m, s);
                chk({tag, "_valid_at_done"}, 96'(ovalid_m), 96'(0));
                fin = ofinal_m;
            end else begin
                chk({tag, "_valid_low"}, 96'(ovalid_m), 96'(0));
                if (poke && cyc == 3) begin
                    istart = 1'b1; imode = 1'b0; ikey = ~key;
                end else begin
                    istart = 1'b0;
                end
                @(negedge iclk);
                cyc++;
            end
        end
        if (!done) chk({tag, "_timeout"}, 96'(0), 96'(1));
        istart = 1'b0;
    endtask

    initial begin
        logic [95:0] f1, f2, k;
        int          dcount;
        ireset = 1'b1; istart = 1'b0; imode = 1'b0; iready = 1'b0; ikey = '0; sel = 0;
        repeat (3) @(negedge iclk);
        for (int d = 0; d < 3; d++) begin
            sel = d;
            #1;
            chk("rst_okey",   96'(okey_m),   96'(0));
            chk("rst_oidx",   96'(oidx_m),   96'(0));
            chk("rst_ovalid", 96'(ovalid_m), 96'(0));
            chk("rst_ofinal", ofinal_m,      96'(0));
            chk("rst_odone",  96'(odone_m),  96'(0));
            chk("rst_obusy",  96'(obusy_m),  96'(0));
        end
        sel = 0;
        @(negedge iclk);
        ireset = 1'b0;
        @(negedge iclk);

        // KLEIN-64 all-zero key: known first two round keys, then model for the rest.
        run_stream(96'(0), 64, 12, 0, 0, "s64z", f1);
        chk("s64z_key0", 96'(seen[0]), 96'(0));
        chk("s64z_key1", 96'(seen[1]), 96'(64'h0000010000777700));
        @(negedge iclk);
        run_final(96'(0), 64, 12, 0, "f64z", f2);
        chk("f64z_vs_stream", f2, f1);

        // Back-to-back starts issued in the odone cycle.
        k = {32'b0, $urandom, $urandom};
        run_final(k, 64, 12, 0, "f64c", f1);
        run_stream(k, 64, 12, 30, 0, "s64bp", f2);
        chk("s64bp_vs_final", f2, f1);

        // istart during a busy run must be ignored.
        @(negedge iclk);
        run_stream({32'b0, $urandom, $urandom}, 64, 12, 0, 1, "s64poke", f1);
        @(negedge iclk);
        run_final({32'b0, $urandom, $urandom}, 64, 12, 1, "f64poke", f1);

        for (int d = 1; d < 3; d++) begin
            int kw, nr;
            kw = (d == 1) ? 80 : 96;
            nr = (d == 1) ? 16 : 20;
            @(negedge iclk);
            sel = d;
            for (int t = 0; t < 2; t++) begin
                k = {$urandom, $urandom, $urandom};
                if (kw == 80) k[95:80] = '0;
                @(negedge iclk);
                run_stream(k, kw, nr, 30, 0, (d == 1) ? "s80" : "s96", f1);
                @(negedge iclk);
                run_final(k, kw, nr, 0, (d == 1) ? "f80" : "f96", f2);
                chk((d == 1) ? "m80_modes" : "m96_modes", f2, f1);
            end
        end

        // Reset in RUN cycle 5 clears everything with no completion pulse.
        @(negedge iclk);
        sel = 0;
        @(negedge iclk);
        istart = 1'b1; imode = 1'b1; ikey = {32'b0, $urandom, $urandom};
        @(negedge iclk);
        istart = 1'b0;
        repeat (4) @(negedge iclk);
        ireset = 1'b1;
        @(negedge iclk);
        chk("mid_rst_okey",   96'(okey_m),   96'(0));
        chk("mid_rst_oidx",   96'(oidx_m),   96'(0));
        chk("mid_rst_ovalid", 96'(ovalid_m), 96'(0));
        chk("mid_rst_ofinal", ofinal_m,      96'(0));
        chk("mid_rst_odone",  96'(odone_m),  96'(0));
        chk("mid_rst_obusy",  96'(obusy_m),  96'(0));
        ireset = 1'b0;
        dcount = 0;
        repeat (20) begin
            @(negedge iclk);
            if (odone_m) dcount++;
        end
        chk("mid_rst_no_done", 96'(dcount), 96'(0));
        run_stream({32'b0, $urandom, $urandom}, 64, 12, 0, 0, "s64after", f1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
